// File: rtl/reset_sequencer_pkg.sv
// Shared constants for the reset sequencer: interrupt vector addresses,
// FSM state encoding and small decode helpers.
package reset_sequencer_pkg;

  // Interrupt vector addresses presented on IntAddrout.
  localparam int IVT_RESET = 63;
  localparam int IVT_PORT1 = 34;

  // Number of TEST rising edges (while RSTn is low) that arms BSL entry.
  localparam int BSL_EDGES = 2;

  // Width of the DEBOUNCE/HOLD cycle counter (covers 1..255).
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_HOLD     = 3'd2,
    ST_REQ      = 3'd3,
    ST_RUN      = 3'd4
  } state_t;

  // States in which the system is held in power-up clear.
  function automatic logic is_puc_state(state_t s);
    return (s == ST_RESET) || (s == ST_DEBOUNCE) || (s == ST_HOLD);
  endfunction

  // States in which PUC requests from PUCsrc are accepted.
  function automatic logic is_src_state(state_t s);
    return (s == ST_HOLD) || (s == ST_REQ) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/reset_sequencer_bsl.sv
// Bootstrap-loader entry detector: counts TEST rising edges while RSTn is
// low and decides, at reset release, whether the BSL entry is pending.
module bsl_entry_detect
  import reset_sequencer_pkg::*;
(
  input  logic MCLK,
  input  logic RSTn,
  input  logic TEST,
  input  logic latch,     // RESET -> DEBOUNCE transition this cycle
  input  logic clr,       // DEBOUNCE -> HOLD or DEBOUNCE abort this cycle
  output logic bsl_pend
);

  localparam logic [1:0] EDGE_SAT = 2'(BSL_EDGES);

  logic       test_q;
  logic [1:0] edge_cnt;
  logic       test_rise;

  assign test_rise = TEST && !test_q;

  // Edge history and saturating edge counter, deliberately outside the pin reset.
  // NOTE: these registers have no reset branch on purpose: the counting
  // happens while RSTn is low, so resetting them would erase what we measure.
  // They are cleared by the sequencer via clr instead.
  always_ff @(posedge MCLK) begin
    if (clr) begin
      test_q   <= 1'b0;
      edge_cnt <= '0;
    end else begin
      test_q <= TEST;
      if (!RSTn && test_rise && (edge_cnt != EDGE_SAT)) begin
        edge_cnt <= edge_cnt + 2'd1;
      end
    end
  end

  // Pending flag captured once at reset release, cleared by the pin reset.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge MCLK) begin
    if (!RSTn) begin
      bsl_pend <= 1'b0;
    end else if (latch) begin
      bsl_pend <= (edge_cnt >= EDGE_SAT) && TEST;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: debounces the RSTn pin, stretches power-up clear, raises
// the reset interrupt, then becomes transparent in the interrupt chain.
// Also records sticky reset causes and forwards the BSL entry decision.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int N_SRC    = 3,
  parameter int IVW      = 6,
  parameter int DEB_CYC  = 4,
  parameter int HOLD_CYC = 8
) (
  input  logic             MCLK,
  input  logic             RSTn,
  input  logic             TEST,
  input  logic [N_SRC-1:0] PUCsrc,
  input  logic             RstCauseClr,
  input  logic             INTACKin,
  input  logic [IVW-1:0]   IntAddrthru,
  output logic             req,
  output logic             INTACKthru,
  output logic [IVW-1:0]   IntAddrout,
  output logic             PUC,
  output logic             BSLenter,
  output logic [N_SRC:0]   RstCause
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [N_SRC:0]   CAUSE_PIN = (N_SRC + 1)'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_SRC:0]     cause_q, cause_d;
  logic [N_SRC-1:0]   src_acc;
  logic               src_any;
  logic               bsl_latch;
  logic               bsl_clr;
  logic               bsl_pend;

  // PUC requests only count once the pin reset has been released.
  assign src_acc = (RSTn && is_src_state(state_q)) ? PUCsrc : '0;
  assign src_any = |src_acc;

  // Strobes for the BSL detector, derived from the current state and pin.
  assign bsl_latch = (state_q == ST_RESET) && RSTn;
  assign bsl_clr   = (state_q == ST_DEBOUNCE) && (!RSTn || (cnt_q == DEB_LAST));

  // State and counter registers with synchronous pin reset.
  always_ff @(posedge MCLK) begin
    if (!RSTn) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic; evaluated for RSTn high (low is handled above).
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RESET: begin
        state_d = ST_DEBOUNCE;
        cnt_d   = '0;
      end
      ST_DEBOUNCE: begin
        if (cnt_q == DEB_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (src_any) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_REQ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REQ: begin
        if (src_any) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (INTACKin) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (src_any) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  // Sticky cause update: a clear is overridden by sources accepted this cycle.
  always_comb begin
    cause_d = RstCauseClr ? '0 : cause_q;
    cause_d[N_SRC:1] = cause_d[N_SRC:1] | src_acc;
  end

  // Cause register; the pin reset leaves only the pin-reset flag set.
  always_ff @(posedge MCLK) begin
    if (!RSTn) begin
      cause_q <= CAUSE_PIN;
    end else begin
      cause_q <= cause_d;
    end
  end

  bsl_entry_detect u_bsl (
    .MCLK     (MCLK),
    .RSTn     (RSTn),
    .TEST     (TEST),
    .latch    (bsl_latch),
    .clr      (bsl_clr),
    .bsl_pend (bsl_pend)
  );

  // Outputs and interrupt-chain mux; a low pin forces the reset values at once.
  always_comb begin
    PUC        = 1'b1;
    req        = 1'b0;
    IntAddrout = '0;
    INTACKthru = 1'b0;
    BSLenter   = 1'b0;
    RstCause   = CAUSE_PIN;
    if (RSTn) begin
      PUC      = is_puc_state(state_q);
      BSLenter = bsl_pend && is_src_state(state_q);
      RstCause = cause_q;
      case (state_q)
        ST_REQ: begin
          req        = 1'b1;
          IntAddrout = IVW'(IVT_RESET);
        end
        ST_RUN: begin
          IntAddrout = IntAddrthru;
          INTACKthru = INTACKin;
        end
        default: begin
          req = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer. Stimulus pushes time-stamped expected
// output snapshots into a scoreboard; a negedge monitor compares them.
module tb_reset_sequencer;
  import reset_sequencer_pkg::*;

  localparam int N_SRC = 3;
  localparam int IVW   = 6;

  logic             MCLK = 1'b0;
  logic             RSTn, TEST, RstCauseClr, INTACKin;
  logic [N_SRC-1:0] PUCsrc;
  logic [IVW-1:0]   IntAddrthru;
  logic             req, INTACKthru, PUC, BSLenter;
  logic [IVW-1:0]   IntAddrout;
  logic [N_SRC:0]   RstCause;

  reset_sequencer #(.N_SRC(N_SRC), .IVW(IVW), .DEB_CYC(4), .HOLD_CYC(8)) dut (
    .MCLK        (MCLK),
    .RSTn        (RSTn),
    .TEST        (TEST),
    .PUCsrc      (PUCsrc),
    .RstCauseClr (RstCauseClr),
    .INTACKin    (INTACKin),
    .IntAddrthru (IntAddrthru),
    .req         (req),
    .INTACKthru  (INTACKthru),
    .IntAddrout  (IntAddrout),
    .PUC         (PUC),
    .BSLenter    (BSLenter),
    .RstCause    (RstCause)
  );

  always #5 MCLK = ~MCLK;

  // Snapshot layout: {PUC, req, BSLenter, INTACKthru, IntAddrout[5:0], RstCause[3:0]}
  localparam logic [13:0] M_PUC   = 14'h2000;
  localparam logic [13:0] M_REQ   = 14'h1000;
  localparam logic [13:0] M_BSL   = 14'h0800;
  localparam logic [13:0] M_ACK   = 14'h0400;
  localparam logic [13:0] M_ADDR  = 14'h03F0;
  localparam logic [13:0] M_CAUSE = 14'h000F;
  localparam logic [13:0] M_ALL   = 14'h3FFF;
  localparam logic [5:0]  A_RST   = 6'(IVT_RESET);
  localparam logic [5:0]  A_P1    = 6'(IVT_PORT1);

  typedef struct {
    string       name;
    int          cyc;
    logic [13:0] val;
    logic [13:0] mask;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge MCLK) cyc <= cyc + 1;

  function automatic logic [13:0] v(logic puc, logic rq, logic bsl, logic ack,
                                    logic [5:0] addr, logic [3:0] cause);
    return {puc, rq, bsl, ack, addr, cause};
  endfunction

  task automatic check(string name, logic ok, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, required %h", name, cyc, got, want);
    end
  endtask

  // Insert keeping the scoreboard ordered by cycle.
  task automatic expect_at(string name, int at, logic [13:0] val, logic [13:0] mask);
    exp_t e;
    int   pos;
    e.name = name; e.cyc = at; e.val = val; e.mask = mask;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > at) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge MCLK);
    #1;
  endtask

  // Monitor: compare every expectation due in this cycle against the DUT.
  always @(negedge MCLK) begin
    logic [13:0] snap;
    snap = {PUC, req, BSLenter, INTACKthru, IntAddrout, RstCause};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      if (cur.cyc < cyc) begin
        check({cur.name, "_missed"}, 1'b0, 32'(cyc), 32'(cur.cyc));
      end else begin
        check(cur.name, ((snap ^ cur.val) & cur.mask) == 14'h0,
              32'(snap & cur.mask), 32'(cur.val & cur.mask));
      end
    end
  end

  initial begin
    int t;
    RSTn = 1'b0; TEST = 1'b0; PUCsrc = '0; RstCauseClr = 1'b0;
    INTACKin = 1'b0; IntAddrthru = '0;

    // Reset state; PUC sources are ignored while in RESET.
    tick(3);
    expect_at("reset_state", cyc, v(1, 0, 0, 0, 0, 4'b0001), M_ALL);
    tick(); PUCsrc = 3'b111;
    tick(); PUCsrc = '0;
    expect_at("src_ignored_reset", cyc, v(1, 0, 0, 0, 0, 4'b0001), M_ALL);

    // Release: DEBOUNCE 4 + HOLD 8 after the first high sample; PUCsrc ignored in DEBOUNCE.
    tick(); t = cyc; RSTn = 1'b1;
    expect_at("deb_puc", t + 3, v(1, 0, 0, 0, 0, 4'b0001), M_PUC | M_REQ | M_BSL);
    expect_at("hold_last", t + 12, v(1, 0, 0, 0, 0, 4'b0001), M_ALL);
    expect_at("req_rise", t + 13, v(0, 1, 0, 0, A_RST, 4'b0001), M_ALL);
    tick(2); PUCsrc = 3'b100;
    tick(); PUCsrc = '0;
    tick(12);
    INTACKin = 1'b1;
    expect_at("ack_consumed", cyc, v(0, 1, 0, 0, A_RST, 4'b0001), M_ALL);
    tick(); INTACKin = 1'b0;
    expect_at("run_entry", cyc, v(0, 0, 0, 0, 0, 4'b0001), M_ALL);

    // Zero-latency feedthrough in RUN.
    tick(); IntAddrthru = A_P1; INTACKin = 1'b1;
    expect_at("feed_ack", cyc, v(0, 0, 0, 1, A_P1, 4'b0001), M_ALL);
    tick(); INTACKin = 1'b0;
    expect_at("feed_idle", cyc, v(0, 0, 0, 0, A_P1, 4'b0001), M_ALL);
    tick(); IntAddrthru = '0;

    // Two simultaneous PUC sources from RUN, then cause clear.
    tick(); t = cyc; PUCsrc = 3'b101;
    expect_at("src_cycle_run", t, v(0, 0, 0, 0, 0, 4'b0001), M_PUC | M_REQ);
    tick(); PUCsrc = '0;
    expect_at("hold_entry", t + 1, v(1, 0, 0, 0, 0, 4'b1011), M_ALL);
    expect_at("hold_end", t + 8, v(1, 0, 0, 0, 0, 4'b1011), M_PUC | M_REQ);
    expect_at("req_after_puc", t + 9, v(0, 1, 0, 0, A_RST, 4'b1011), M_ALL);
    tick(9); RstCauseClr = 1'b1;
    tick(); RstCauseClr = 1'b0;
    expect_at("cause_cleared", cyc, v(0, 1, 0, 0, A_RST, 4'b0000), M_ALL);

    // PUC source in REQ restarts HOLD with a full count.
    tick(); t = cyc; PUCsrc = 3'b010;
    expect_at("req_before_restart", t, v(0, 1, 0, 0, A_RST, 4'b0000), M_REQ);
    tick(); PUCsrc = '0;
    expect_at("req_drop", t + 1, v(1, 0, 0, 0, 0, 4'b0100), M_ALL);
    expect_at("req_hold_end", t + 8, v(1, 0, 0, 0, 0, 4'b0100), M_PUC | M_REQ);
    expect_at("req_return", t + 9, v(0, 1, 0, 0, A_RST, 4'b0100), M_ALL);
    tick(8); INTACKin = 1'b1;
    tick(); INTACKin = 1'b0;

    // Accepted source beats a same-cycle clear; a source in HOLD restarts it.
    tick(); t = cyc; PUCsrc = 3'b001; RstCauseClr = 1'b1;
    tick(); PUCsrc = '0; RstCauseClr = 1'b0;
    expect_at("clr_loses", t + 1, v(1, 0, 0, 0, 0, 4'b0010), M_PUC | M_CAUSE);
    tick(3); PUCsrc = 3'b100;
    tick(); PUCsrc = '0;
    expect_at("hold_restart", t + 12, v(1, 0, 0, 0, 0, 4'b1010), M_PUC | M_REQ);
    expect_at("req_after_restart", t + 13, v(0, 1, 0, 0, A_RST, 4'b1010), M_ALL);
    tick(8); INTACKin = 1'b1;
    tick(); INTACKin = 1'b0;

    // Bouncing pin: 0/1/0/1/0/1 then held high.
    tick(); t = cyc; RSTn = 1'b0;
    expect_at("pin_low_gated", t, v(1, 0, 0, 0, 0, 4'b0001), M_ALL);
    for (int k = 1; k < 18; k++) begin
      expect_at("bounce_puc", t + k, v(1, 0, 0, 0, 0, 4'b0001), M_PUC | M_REQ);
    end
    expect_at("bounce_req", t + 18, v(0, 1, 0, 0, A_RST, 4'b0001), M_ALL);
    tick(); RSTn = 1'b1;
    tick(); RSTn = 1'b0;
    tick(); RSTn = 1'b1;
    tick(); RSTn = 1'b0;
    tick(); RSTn = 1'b1;
    tick(13); INTACKin = 1'b1;
    tick(); INTACKin = 1'b0;

    // BSL entry: two TEST rising edges during reset, TEST held high at release.
    tick(); t = cyc; RSTn = 1'b0;
    tick(2); TEST = 1'b1;
    tick();  TEST = 1'b0;
    tick();  TEST = 1'b1;
    tick(2); RSTn = 1'b1;
    expect_at("bsl_deb", t + 10, v(1, 0, 0, 0, 0, 4'b0001), M_PUC | M_BSL);
    expect_at("bsl_hold_entry", t + 11, v(1, 0, 1, 0, 0, 4'b0001), M_ALL);
    expect_at("bsl_req", t + 19, v(0, 1, 1, 0, A_RST, 4'b0001), M_ALL);
    tick(13); INTACKin = 1'b1;
    tick(); INTACKin = 1'b0; PUCsrc = 3'b001;
    expect_at("bsl_run", t + 20, v(0, 0, 1, 0, 0, 4'b0001), M_PUC | M_REQ | M_BSL);
    tick(); PUCsrc = '0;
    expect_at("bsl_puc_only", t + 21, v(1, 0, 1, 0, 0, 4'b0011), M_ALL);
    tick(8); INTACKin = 1'b1;
    tick(); INTACKin = 1'b0; TEST = 1'b0;

    // Single TEST rising edge: no BSL entry.
    tick(); t = cyc; RSTn = 1'b0;
    expect_at("bsl_low_gated", t, v(1, 0, 0, 0, 0, 4'b0001), M_PUC | M_BSL);
    tick(2); TEST = 1'b1;
    tick(2); RSTn = 1'b1;
    expect_at("single_pulse_hold", t + 9, v(1, 0, 0, 0, 0, 4'b0001), M_ALL);
    expect_at("single_pulse_req", t + 17, v(0, 1, 0, 0, A_RST, 4'b0001), M_ALL);
    tick(16);

    // Anything still queued was never reached.
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      check({cur.name, "_unreached"}, 1'b0, 32'(cyc), 32'(cur.cyc));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter N_SRC, default 3: number of PUC sources besides the RSTn pin (1..8).
REQ-002 SHALL have parameter IVW, default 6: interrupt address width.
REQ-003 SHALL have parameter DEB_CYC, default 4: consecutive RSTn-high cycles needed to accept release (1..255).
REQ-004 SHALL have parameter HOLD_CYC, default 8: PUC assertion length in cycles (1..255).
REQ-005 SHALL have port MCLK, input, 1: the single clock. All logic is on its rising edge.
REQ-006 SHALL have port RSTn, input, 1: reset pin. Reset is synchronous and active-low.
REQ-007 SHALL have port TEST, input, 1: TEST pin, used for BSL entry.
REQ-008 SHALL have port PUCsrc, input, N_SRC: one-cycle PUC requests (watchdog, flash violation, software).
REQ-009 SHALL have port RstCauseClr, input, 1: clears the sticky cause flags.
REQ-010 SHALL have port INTACKin, input, 1: interrupt acknowledge from the CPU.
REQ-011 SHALL have port IntAddrthru, input, IVW: vector from the lower-priority chain.
REQ-012 SHALL have port req, output, 1: reset interrupt request.
REQ-013 SHALL have port INTACKthru, output, 1: acknowledge passed down the chain.
REQ-014 SHALL have port IntAddrout, output, IVW: vector passed to the CPU.
REQ-015 SHALL have port PUC, output, 1: power-up clear to the system.
REQ-016 SHALL have port BSLenter, output, 1: bootstrap-loader entry flag.
REQ-017 SHALL have port RstCause, output, N_SRC+1: sticky flags. Bit 0 is the pin reset; bit k is PUCsrc[k-1].

Function
REQ-018 SHALL implement the states RESET, DEBOUNCE, HOLD, REQ and RUN.
REQ-019 In any state, a cycle with RSTn=0 SHALL move the FSM to RESET on the next edge.
REQ-020 In RESET, RSTn=1 SHALL move to DEBOUNCE. DEBOUNCE SHALL last DEB_CYC cycles, then move to HOLD.
REQ-021 Any RSTn low during DEBOUNCE SHALL return the FSM to RESET. This gives bounce rejection.
REQ-022 HOLD SHALL last HOLD_CYC cycles, then move to REQ.
REQ-023 In REQ, INTACKin=1 SHALL move the FSM to RUN on the next edge.
REQ-024 In RUN, any PUCsrc bit high SHALL move the FSM to HOLD.
REQ-025 A PUCsrc bit high in HOLD or REQ SHALL restart HOLD with a full count.
REQ-026 PUCsrc SHALL be ignored in RESET and DEBOUNCE.
REQ-027 Each accepted PUCsrc[k] SHALL set RstCause[k+1]. Simultaneous sources SHALL all be recorded.
REQ-028 RstCauseClr SHALL clear RstCause, except that a source accepted in the same cycle wins.
REQ-029 The PUC output SHALL be 1 in RESET, DEBOUNCE and HOLD, and 0 in REQ and RUN.
REQ-030 The req output SHALL be 1 only in REQ.
REQ-031 In REQ, IntAddrout SHALL equal IVT_RESET and INTACKthru SHALL be 0; the acknowledge is consumed.
REQ-032 In RUN, IntAddrout SHALL equal IntAddrthru and INTACKthru SHALL equal INTACKin, both combinationally with zero latency.
REQ-033 In RESET, DEBOUNCE and HOLD, IntAddrout and INTACKthru SHALL both be 0.
REQ-034 The BSL detector SHALL count rising edges of TEST while RSTn=0, saturating at 2.
REQ-035 On the RESET→DEBOUNCE transition, if the edge count is ≥2 and TEST=1, BSLpend SHALL be latched to 1; otherwise it SHALL be latched to 0.
REQ-036 BSLenter SHALL be 1 from HOLD entry onward, until the next RSTn low.
REQ-037 A DEBOUNCE abort SHALL clear the edge count.
REQ-038 PUC-only cycles (from PUCsrc) SHALL NOT change BSLenter.

Reset
REQ-039 While RSTn=0, the following SHALL hold: state=RESET, counters=0, req=0, PUC=1, BSLenter=0, RstCause=1 (bit 0 only), IntAddrout=0, INTACKthru=0.
REQ-040 The BSL edge counter and its TEST history register SHALL be exempt from RSTn. They SHALL be cleared on DEBOUNCE→HOLD and on DEBOUNCE abort.

Structure
REQ-041 IVT_RESET, IVT_PORT1 and the FSM state encodings SHALL live in the shared NEW/PARAMS.v.
REQ-042 TEST edge counting and BSLpend SHALL form the sub-module bsl_entry_detect. The FSM, counters, cause register and feedthrough mux SHALL stay in reset_sequencer.

Verification
REQ-043 Release RSTn with N_SRC=3, DEB_CYC=4, HOLD_CYC=8 → PUC low exactly 12 cycles after RSTn high, req=1, IntAddrout=IVT_RESET; INTACKin pulse → req=0, INTACKthru=0.
REQ-044 In RUN, drive IntAddrthru=IVT_PORT1 and pulse INTACKin → both appear on IntAddrout and INTACKthru in the same cycle.
REQ-045 RSTn 0/1/0/1/0/1 at one-cycle spacing, then held 1 → PUC stays 1 and req rises DEB_CYC+HOLD_CYC cycles after the final rise; RstCause=3'b...0001.
REQ-046 In RUN, pulse PUCsrc[0] and PUCsrc[2] together → PUC=1 for 8 cycles, then req=1; RstCause=4'b1011; RstCauseClr → RstCause=0.
REQ-047 RSTn low, two TEST pulses, TEST=1, release RSTn → BSLenter=1 at HOLD entry. Same with a single TEST pulse → BSLenter=0.
REQ-048 PUCsrc[1] pulsed in REQ → req drops, HOLD restarts for a full 8 cycles, then req returns.
